ws2812_rx: RTL

Decodes a WS2812-format single-wire serial stream into 24-bit GRB words. It is the receive-side counterpart to the LED driver in this design. It sits in the loopback/verification path and the LED-chain monitor, so transmitted frames can be checked in-system. It measures each high pulse to classify bits, assembles words MSB first, and detects the low reset gap that ends a frame.

---
 rtl/ws2812_pkg.sv | 29 ++
 rtl/ws2812_sync_edge.sv | 31 +++
 rtl/ws2812_rx.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: FSM state encoding, word width and bit-timing fractions.
// Used by the receiver now and intended for the LED driver as well.
package ws2812_pkg;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        IDLE = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } ws2812_state_t;

    localparam int unsigned BITS_PER_LED = 24;

    // High-pulse limits expressed as num/den microseconds
    localparam int unsigned T_MIN_NUM = 15;
    localparam int unsigned T_MIN_DEN = 100;
    localparam int unsigned T_THR_NUM = 63;
    localparam int unsigned T_THR_DEN = 100;
    localparam int unsigned T_MAX_US  = 2;

    function automatic int unsigned us_to_cycles(
        input int unsigned clock_frequency,
        input int unsigned num,
        input int unsigned den
    );
        return ((clock_frequency / 1000000) * num) / den;
    endfunction

endpackage

// File: rtl/ws2812_sync_edge.sv
// Two-flop synchroniser for the WS2812 line, plus a third stage giving
// registered rise/fall pulses aligned with the delayed level.
module ws2812_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            meta  <= din;
            sync  <= meta;
            level <= sync;
            rise  <= sync & ~level;
            fall  <= ~sync & level;
        end
    end

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 single-wire receiver: classifies high pulses into bits, assembles GRB words
// MSB first and flags the low reset gap. Define WS2812_FORWARD_EN to add o_Dout chain forwarding.
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 100000000,
    parameter int unsigned RESET_GAP_US    = 50
) (
    input  logic        i_Clock,
    input  logic        i_Reset_n,
    input  logic        i_Din,
    output logic [23:0] o_Data,
    output logic        o_Valid,
    output logic [7:0]  o_Led_Index,
    output logic        o_Frame_End,
    output logic        o_Error,
    output logic        o_Busy
`ifdef WS2812_FORWARD_EN
    ,
    output logic        o_Dout
`endif
);

    localparam int unsigned T_MIN = us_to_cycles(CLOCK_FREQUENCY, T_MIN_NUM, T_MIN_DEN);
    localparam int unsigned T_THR = us_to_cycles(CLOCK_FREQUENCY, T_THR_NUM, T_THR_DEN);
    localparam int unsigned T_MAX = us_to_cycles(CLOCK_FREQUENCY, T_MAX_US, 1);
    localparam int unsigned T_GAP = us_to_cycles(CLOCK_FREQUENCY, RESET_GAP_US, 1);

    localparam logic [16:0] T_MIN_C = 17'(T_MIN);
    localparam logic [16:0] T_THR_C = 17'(T_THR);
    localparam logic [16:0] T_MAX_C = 17'(T_MAX);
    localparam logic [16:0] T_GAP_C = 17'(T_GAP);

    localparam logic [1:0] ST_SYNC = SYNC;
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_HIGH = HIGH;
    localparam logic [1:0] ST_LOW  = LOW;

    localparam logic [4:0] LAST_BIT = 5'(BITS_PER_LED - 1);

    logic        level;
    logic        rise;
    logic        fall;
    logic [1:0]  state;
    logic [15:0] timer;
    logic [16:0] t;
    logic        bit_val;
    logic [22:0] shift;
    logic [4:0]  bit_cnt;
    logic [7:0]  word_cnt;

    ws2812_sync_edge u_sync_edge (
        .clk     (i_Clock),
        .reset_n (i_Reset_n),
        .din     (i_Din),
        .level   (level),
        .rise    (rise),
        .fall    (fall)
    );

    // The timer restarts on the edge pulse, so t counts the edge cycle itself.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            timer <= '0;
        end else if (rise || fall || (state == ST_SYNC && level)) begin
            timer <= '0;
        end else if (timer != '1) begin
            timer <= timer + 16'd1;
        end
    end

    always_comb begin
        t       = {1'b0, timer} + 17'd1;
        bit_val = (t >= T_THR_C);
    end

    assign o_Busy = (state == ST_HIGH) || (state == ST_LOW);

`ifdef WS2812_FORWARD_EN
    logic fwd_en;
    logic fwd_dly;
`endif

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            state       <= ST_SYNC;
            shift       <= '0;
            bit_cnt     <= '0;
            word_cnt    <= '0;
            o_Data      <= '0;
            o_Valid     <= 1'b0;
            o_Led_Index <= '0;
            o_Frame_End <= 1'b0;
            o_Error     <= 1'b0;
`ifdef WS2812_FORWARD_EN
            fwd_en      <= 1'b0;
`endif
        end else begin
            o_Valid     <= 1'b0;
            o_Frame_End <= 1'b0;
            o_Error     <= 1'b0;
            case (state)
                ST_SYNC: begin
                    bit_cnt  <= '0;
                    word_cnt <= '0;
`ifdef WS2812_FORWARD_EN
                    fwd_en   <= 1'b0;
`endif
                    if (!level && !fall && t >= T_GAP_C) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (rise) begin
                        state <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (fall) begin
                        if (t < T_MIN_C) begin
                            o_Error <= 1'b1;
                            state   <= ST_SYNC;
                        end else begin
                            shift <= {shift[21:0], bit_val};
                            state <= ST_LOW;
                            if (bit_cnt == LAST_BIT) begin
                                o_Data      <= {shift, bit_val};
                                o_Valid     <= 1'b1;
                                o_Led_Index <= word_cnt;
                                bit_cnt     <= '0;
                                if (word_cnt != '1) begin
                                    word_cnt <= word_cnt + 8'd1;
                                end
`ifdef WS2812_FORWARD_EN
                                fwd_en <= 1'b1;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end else if (t >= T_MAX_C) begin
                        o_Error <= 1'b1;
                        state   <= ST_SYNC;
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        state <= ST_HIGH;
                    end else if (t >= T_GAP_C) begin
                        o_Frame_End <= 1'b1;
                        o_Error     <= (bit_cnt != '0);
                        bit_cnt     <= '0;
                        word_cnt    <= '0;
                        state       <= ST_IDLE;
`ifdef WS2812_FORWARD_EN
                        fwd_en      <= 1'b0;
`endif
                    end
                end
                default: state <= ST_SYNC;
            endcase
        end
    end

`ifdef WS2812_FORWARD_EN
    // level is already one clock behind the synchroniser; two more stages make three.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            fwd_dly <= 1'b0;
            o_Dout  <= 1'b0;
        end else begin
            fwd_dly <= level;
            o_Dout  <= (fwd_en && state != ST_SYNC) ? fwd_dly : 1'b0;
        end
    end
`endif

endmodule
